el2_dec_gpr_wb_queue: RTL and testbench

Write-back queue that is the producer side of the decode-stage GPR file write port 2. It captures late, out-of-pipe results (non-blocking load returns from the LSU and divider results), buffers them in order, and drains them one per cycle onto the GPR write port whenever the port is free. It also publishes a per-register pending vector so decode can stall reads of registers with an outstanding late write.

---
 rtl/el2_dec_gpr_wb_queue.sv | 108 ++++++++++
 tb/tb_el2_dec_gpr_wb_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/el2_dec_gpr_wb_queue.sv
// Write-back queue for late GPR results (non-blocking loads, divider).
// Buffers results in order and drains one per cycle onto GPR write port 2.
module el2_dec_gpr_wb_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        scan_mode,
  input  logic        lsu_nb_valid,
  input  logic [4:0]  lsu_nb_rd,
  input  logic [31:0] lsu_nb_data,
  input  logic        div_valid,
  input  logic [4:0]  div_rd,
  input  logic [31:0] div_data,
  input  logic        port_free,
  output logic        wb_ready,
  output logic        wen2,
  output logic [4:0]  waddr2,
  output logic [31:0] wd2,
  output logic [31:1] gpr_pend,
  output logic        wb_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [4:0]    rd_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];

  logic          lsu_keep;
  logic          div_keep;
  logic          drain;
  logic [PW-1:0] div_slot;
  logic [PW-1:0] wr_adv;
  logic [DEPTH-1:0] ent_valid;
  logic [PW-1:0] off;

  logic unused_scan;
  assign unused_scan = scan_mode;

  // Writes to x0 are architecturally dead, so they never occupy a slot.
  assign lsu_keep   = lsu_nb_valid & (lsu_nb_rd != 5'd0);
  assign div_keep   = div_valid & (div_rd != 5'd0);
  assign drain      = (count != CW'(0)) & port_free;
  assign div_slot   = wr_ptr + PW'(lsu_keep);
  assign wr_adv     = PW'({1'b0, lsu_keep} + {1'b0, div_keep});
  assign count_next = count + CW'(lsu_keep) + CW'(div_keep) - CW'(drain);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + wr_adv;
      rd_ptr <= rd_ptr + PW'(drain);
      count  <= count_next;
    end
  end

  // Payload storage; validity comes only from count/rd_ptr, so no reset needed.
  always_ff @(posedge clk) begin
    if (lsu_keep) begin
      rd_q[wr_ptr]   <= lsu_nb_rd;
      data_q[wr_ptr] <= lsu_nb_data;
    end
    if (div_keep) begin
      rd_q[div_slot]   <= div_rd;
      data_q[div_slot] <= div_data;
    end
  end

  // An entry is live when its distance from the head is below count.
  always_comb begin
    ent_valid = '0;
    off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off          = PW'(i) - rd_ptr;
      ent_valid[i] = (CW'(off) < count);
    end
  end

  always_comb begin
    gpr_pend = '0;
    for (int j = 1; j < 32; j++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_valid[i] && (rd_q[i] == 5'(j))) gpr_pend[j] = 1'b1;
      end
    end
  end

  assign wen2     = drain;
  assign waddr2   = drain ? rd_q[rd_ptr]   : 5'd0;
  assign wd2      = drain ? data_q[rd_ptr] : 32'd0;
  assign wb_empty = (count == CW'(0));
  assign wb_ready = (count <= CW'(DEPTH - 2));

`ifdef RV_ASSERT_ON
  logic [CW:0] occ_next;
  assign occ_next = {1'b0, count} + (CW+1)'(lsu_keep) + (CW+1)'(div_keep) - (CW+1)'(drain);
  assert property (@(posedge clk) disable iff (!rst_l) (occ_next <= (CW+1)'(DEPTH)));
`endif

endmodule

// File: tb/tb_el2_dec_gpr_wb_queue.sv
// Self-checking bench for el2_dec_gpr_wb_queue: directed scenarios plus
// randomized traffic checked against an in-order queue reference model.
module tb_el2_dec_gpr_wb_queue;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_ent_t;

  logic        clk;
  logic        rst_l;
  logic        scan_mode;
  logic        lsu_nb_valid;
  logic [4:0]  lsu_nb_rd;
  logic [31:0] lsu_nb_data;
  logic        div_valid;
  logic [4:0]  div_rd;
  logic [31:0] div_data;
  logic        port_free;
  logic        wb_ready;
  logic        wen2;
  logic [4:0]  waddr2;
  logic [31:0] wd2;
  logic [31:1] gpr_pend;
  logic        wb_empty;

  el2_dec_gpr_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .scan_mode    (scan_mode),
    .lsu_nb_valid (lsu_nb_valid),
    .lsu_nb_rd    (lsu_nb_rd),
    .lsu_nb_data  (lsu_nb_data),
    .div_valid    (div_valid),
    .div_rd       (div_rd),
    .div_data     (div_data),
    .port_free    (port_free),
    .wb_ready     (wb_ready),
    .wen2         (wen2),
    .waddr2       (waddr2),
    .wd2          (wd2),
    .gpr_pend     (gpr_pend),
    .wb_empty     (wb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passed = 0;
  wb_ent_t     q[$];

  logic        obs_wen;
  logic [4:0]  obs_addr;
  logic [31:0] obs_wd;
  logic [31:1] obs_pend;
  logic        obs_empty;
  logic        obs_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One cycle: drive inputs, compare outputs with the model, then advance the model.
  task automatic step(input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input bit dv, input logic [4:0] drd, input logic [31:0] dd,
                      input bit pf);
    bit          e_wen;
    logic [4:0]  e_addr;
    logic [31:0] e_wd;
    logic [31:1] e_pend;
    @(negedge clk);
    lsu_nb_valid = lv; lsu_nb_rd = lrd; lsu_nb_data = ld;
    div_valid    = dv; div_rd    = drd; div_data    = dd;
    port_free    = pf;
    #1;
    e_wen  = (q.size() != 0) && pf;
    e_addr = e_wen ? q[0].rd   : 5'd0;
    e_wd   = e_wen ? q[0].data : 32'd0;
    e_pend = '0;
    foreach (q[i]) e_pend[q[i].rd] = 1'b1;
    obs_wen = wen2; obs_addr = waddr2; obs_wd = wd2;
    obs_pend = gpr_pend; obs_empty = wb_empty; obs_ready = wb_ready;
    chk("wen2",     32'(wen2),     32'(e_wen));
    chk("waddr2",   32'(waddr2),   32'(e_addr));
    chk("wd2",      wd2,           e_wd);
    chk("gpr_pend", 32'(gpr_pend), 32'(e_pend));
    chk("wb_empty", 32'(wb_empty), 32'(q.size() == 0));
    chk("wb_ready", 32'(wb_ready), 32'(q.size() <= DEPTH - 2));
    if (e_wen) void'(q.pop_front());
    if (lv && lrd != 5'd0) q.push_back('{rd: lrd, data: ld});
    if (dv && drd != 5'd0) q.push_back('{rd: drd, data: dd});
  endtask

  task automatic idle(input bit pf);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, pf);
  endtask

  initial begin
    bit          pair;
    bit          pf;
    logic [4:0]  r1, r2;
    int          guard;

    scan_mode = 1'b0;
    lsu_nb_valid = 1'b0; lsu_nb_rd = '0; lsu_nb_data = '0;
    div_valid = 1'b0; div_rd = '0; div_data = '0;
    port_free = 1'b1;
    rst_l = 1'b0;
    #3;
    chk("rst_wen2",     32'(wen2),     32'd0);
    chk("rst_waddr2",   32'(waddr2),   32'd0);
    chk("rst_wd2",      wd2,           32'd0);
    chk("rst_gpr_pend", 32'(gpr_pend), 32'd0);
    chk("rst_wb_empty", 32'(wb_empty), 32'd1);
    chk("rst_wb_ready", 32'(wb_ready), 32'd1);
    @(negedge clk);
    rst_l = 1'b1;

    // Single load
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1);
    idle(1'b1);
    chk("single_wen",  32'(obs_wen),     32'd1);
    chk("single_addr", 32'(obs_addr),    32'd5);
    chk("single_wd",   obs_wd,           32'hDEADBEEF);
    chk("single_pend", 32'(obs_pend[5]), 32'd1);
    idle(1'b1);
    chk("single_empty", 32'(obs_empty), 32'd1);
    chk("single_clear", 32'(obs_pend),  32'd0);

    // Dual arrival to the same register
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 1'b1);
    idle(1'b1);
    chk("dual_first",  obs_wd,           32'h11);
    chk("dual_pend0",  32'(obs_pend[3]), 32'd1);
    idle(1'b1);
    chk("dual_second", obs_wd,           32'h22);
    chk("dual_pend1",  32'(obs_pend[3]), 32'd1);
    idle(1'b1);
    chk("dual_empty",  32'(obs_empty),   32'd1);

    // x0 discard
    step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 1'b1);
    idle(1'b1);
    chk("x0_wen",   32'(obs_wen),   32'd0);
    chk("x0_empty", 32'(obs_empty), 32'd1);

    // Backpressure to full, then ordered drain
    for (int k = 1; k <= 4; k++) step(1'b1, 5'(k), 32'(k * 16), 1'b0, 5'd0, 32'd0, 1'b0);
    idle(1'b0);
    chk("full_pend",  32'(obs_pend),  32'h0000000F);
    chk("full_ready", 32'(obs_ready), 32'd0);
    chk("full_wen",   32'(obs_wen),   32'd0);
    for (int k = 1; k <= 4; k++) begin
      idle(1'b1);
      chk("full_drain_addr", 32'(obs_addr), 32'(k));
    end
    idle(1'b1);
    chk("full_empty", 32'(obs_empty), 32'd1);

    // Alternating pair/single enqueues with toggling port_free, across wraps
    for (int k = 0; k < 10; k++) begin
      pair  = (k % 2 == 0);
      guard = 0;
      while (q.size() > DEPTH - (pair ? 2 : 1) && guard < 20) begin
        idle(1'b1);
        guard++;
      end
      pf = (k % 3 != 0);
      r1 = 5'($urandom_range(1, 31));
      r2 = 5'($urandom_range(1, 31));
      step(1'b1, r1, $urandom, pair, r2, $urandom, pf);
    end
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      idle(1'b1);
      guard++;
    end
    chk("wrap_drained", 32'(q.size()), 32'd0);

    // Randomized traffic honouring wb_ready
    for (int k = 0; k < 300; k++) begin
      bit lv, dv, ok;
      ok = (q.size() <= DEPTH - 2);
      lv = ok && ($urandom_range(0, 2) != 0);
      dv = ok && ($urandom_range(0, 2) == 0);
      step(lv, 5'($urandom_range(0, 31)), $urandom,
           dv, 5'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 3) != 0));
    end
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      idle(1'b1);
      guard++;
    end

    // Async reset mid-cycle with three entries held
    step(1'b1, 5'd7, 32'h7, 1'b1, 5'd8, 32'h8, 1'b0);
    step(1'b1, 5'd9, 32'h9, 1'b0, 5'd0, 32'd0, 1'b0);
    @(negedge clk);
    lsu_nb_valid = 1'b0; div_valid = 1'b0; port_free = 1'b1;
    #1;
    chk("pre_rst_wen", 32'(wen2), 32'd1);
    #1;
    rst_l = 1'b0;
    #1;
    chk("arst_wen2",     32'(wen2),     32'd0);
    chk("arst_waddr2",   32'(waddr2),   32'd0);
    chk("arst_wd2",      wd2,           32'd0);
    chk("arst_gpr_pend", 32'(gpr_pend), 32'd0);
    chk("arst_wb_empty", 32'(wb_empty), 32'd1);
    chk("arst_wb_ready", 32'(wb_ready), 32'd1);
    q.delete();
    @(negedge clk);
    rst_l = 1'b1;
    for (int k = 0; k < 4; k++) idle(1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
